rr_mux_arbiter_4ch: RTL
=======================

// Module: rr_mux_arbiter_4ch
// PURPOSE
//   Round-robin arbiter that shares one 4:1 data mux between four requesters.
//   Grants the mux to one requester at a time, drives the registered 2-bit select and a one-hot grant,
//   and steers the granted lane to a single output.
//   Sits in front of the mux/decoder datapath and replaces a free-running select.
// PARAMETERS
//   DATA_W    1   width of each requester data lane
//   HOLD_MAX  8   max consecutive grant cycles before forced rotation (2..255); used only with RR_HOLD_LIMIT_EN
// PORTS
//   clk       in   1         single clock, rising edge
//   rst       in   1         asynchronous, active-high reset
//   req       in   4         request per requester; held high for as long as the mux is wanted
//   data_in   in   4*DATA_W  lane i = data_in[i*DATA_W +: DATA_W]
//   grant     out  4         one-hot grant, registered; 4'b0000 when idle
//   select    out  2         registered mux select = index of granted lane
//   busy      out  1         1 while any grant is active
//   data_out  out  DATA_W    lane[select] when busy, else all-zero (never Z)
// BEHAVIOUR
//   Reset (async, rst=1):
//     - State IDLE; grant=0; select=0; busy=0; data_out=0.
//     - Last-winner pointer=3, so requester 0 has first priority. Hold counter=0.
//   Arbitration:
//     - Winner = first asserted req scanning from last+1 upward, modulo 4.
//     - On a grant: pointer <= winner, counter <= 0.
//   IDLE:
//     - Any req=1 at an edge: grant/select/busy update at that edge. Latency is 1 clock from req to grant; state <= GRANT.
//     - req=0: stay IDLE.
//   GRANT (owner g):
//     - req[g]=1: hold grant, select unchanged; counter increments, saturating at 255.
//     - req[g]=0 with another req pending: back-to-back switch at the same edge, no idle cycle.
//       The new winner comes from the rotation, excluding g.
//     - req[g]=0 with no other req pending: grant=0, busy=0, state <= IDLE.
//   Invariants:
//     - grant is always one-hot or zero.
//     - select changes only at an edge where grant changes.
//     - When busy=0, select keeps its last value.
//   Simultaneous requests: resolved purely by rotation; a requester that lost waits at most 3 grants.
//   data_out is combinational from registered select/busy and data_in; no added latency on data.
//   Reset mid-grant: outputs clear immediately (async). After release, arbitration restarts with requester 0 first.
//   Requests arriving during reset are ignored until the first edge with rst=0.
// CONFIGURATION
//   RR_HOLD_LIMIT_EN defined:
//     - At an edge where counter==HOLD_MAX-1 and another req is pending, the owner is forcibly rotated out, even if its req is still 1.
//     - The next owner is chosen by normal rotation.
//     - With no other req pending, the owner keeps the grant and the counter saturates.
//   RR_HOLD_LIMIT_EN undefined:
//     - No forced rotation; the owner holds until its req drops.
//     - HOLD_MAX is ignored; the counter may be omitted.
// TESTING
//   1. Reset
//      - rst=1 with req=4'b1111 -> grant=0, select=0, busy=0, data_out=0.
//      - Release rst, hold req=4'b1111 -> grant=4'b0001 after the first edge.
//   2. Single requester
//      - req=4'b0100 -> next edge grant=4'b0100, select=2, data_out=data_in lane 2.
//      - Drop req -> next edge grant=0, busy=0.
//   3. Round robin
//      - req=4'b1111, each owner drops req for 1 cycle after being granted.
//      - Grant order 0,1,2,3,0 with no idle cycle between owners.
//   4. Rotation skip
//      - Owner 1 releases while req=4'b1001 -> next grant=4'b1000 (3 precedes 0 after last=1).
//   5. Reset mid-operation
//      - rst pulsed between edges while grant=4'b0010 -> outputs zero immediately.
//      - Afterwards, req=4'b0011 -> grant=4'b0001.
//   6. RR_HOLD_LIMIT_EN, HOLD_MAX=4
//      - req=4'b0011 held constant -> grant alternates 0,1,0 every 4 cycles.
//      - With req=4'b0001 only -> grant stays 4'b0001 indefinitely.

Source files
------------

// File: rtl/rr_mux_arbiter_4ch.sv
// Round-robin arbiter sharing one 4:1 data mux between four requesters.
// Define RR_HOLD_LIMIT_EN to force rotation after HOLD_MAX consecutive grant cycles.
module rr_mux_arbiter_4ch #(
    parameter int DATA_W   = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   data_in,
    output logic [3:0]            grant,
    output logic [1:0]            select,
    output logic                  busy,
    output logic [DATA_W-1:0]     data_out
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t      r_state;
    logic [3:0]  r_grant;
    logic [1:0]  r_select;
    logic        r_busy;
    logic [1:0]  r_last;

    logic [3:0]  w_cand;
    logic [1:0]  w_idx;
    logic [1:0]  w_winner;
    logic        w_found;
    logic        w_ownerReq;
    logic        w_holdExpired;

    // The current owner is masked out so a switch or forced rotation never
    // re-picks it; in IDLE the grant is zero and every request competes.
    assign w_cand     = req & ~r_grant;
    assign w_ownerReq = |(req & r_grant);

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        w_idx    = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

`ifdef RR_HOLD_LIMIT_EN
    logic [7:0] r_count;

    assign w_holdExpired = (r_count == 8'(HOLD_MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (r_state == S_IDLE || !w_ownerReq || (w_holdExpired && w_found)) begin
            r_count <= 8'd0;
        end else if (r_count != 8'hFF) begin
            r_count <= r_count + 8'd1;
        end
    end
`else
    logic [7:0] w_unusedHoldMax;

    assign w_unusedHoldMax = 8'(HOLD_MAX);
    assign w_holdExpired   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= 4'b0000;
            r_select <= 2'd0;
            r_busy   <= 1'b0;
            r_last   <= 2'd3;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state  <= S_GRANT;
                        r_grant  <= 4'b0001 << w_winner;
                        r_select <= w_winner;
                        r_busy   <= 1'b1;
                        r_last   <= w_winner;
                    end
                end
                S_GRANT: begin
                    if (w_ownerReq && !(w_holdExpired && w_found)) begin
                        r_state <= S_GRANT;
                    end else if (w_found) begin
                        r_grant  <= 4'b0001 << w_winner;
                        r_select <= w_winner;
                        r_last   <= w_winner;
                    end else begin
                        r_state <= S_IDLE;
                        r_grant <= 4'b0000;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant  = r_grant;
    assign select = r_select;
    assign busy   = r_busy;

    always_comb begin
        data_out = '0;
        if (r_busy) begin
            data_out = data_in[r_select*DATA_W +: DATA_W];
        end
    end

endmodule
